// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch-stage sequencer: PC vectors, PCsel one-hot
// bit positions, fetch FSM encoding and the buffered-fetch record.
package pc_sequencer_pkg;

    localparam logic [31:0] RESET_VEC = 32'hBFC0_0000;
    localparam logic [31:0] EXC_VEC   = 32'hBFC0_0180;

    localparam int SEL_INC  = 0;
    localparam int SEL_ADD  = 1;
    localparam int SEL_JUMP = 2;
    localparam int SEL_REG  = 3;
    localparam int SEL_VEC  = 4;

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        REQ      = 2'd1,
        SKID     = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } fetch_entry_t;

    // Any select other than plain increment changes the fetch stream.
    function automatic logic is_redirect(input logic [4:0] sel);
        return |sel[4:1];
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory request/acknowledge channel between the fetch sequencer
// (master) and the instruction memory (slave).
interface pc_sequencer_if;

    logic        ireq;
    logic [31:0] iaddr;
    logic        iack;
    logic [31:0] idata;

    modport master (output ireq, output iaddr, input iack, input idata);
    modport slave  (input ireq, input iaddr, output iack, output idata);

endinterface

// File: rtl/pc_sequencer_target.sv
// Combinational redirect target: selects among branch add, jump, register and
// exception vector using the one-hot PCsel from EX.
module pc_target
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] ex_pc,
    input  logic [4:0]  pc_sel,
    input  logic [31:0] pc_offset,
    input  logic [25:0] pc_jump,
    input  logic [31:0] reg_target,
    output logic [31:0] target
);

    logic [31:0] base;
    logic [31:0] raw;

    assign base = ex_pc + 32'd4;

    always_comb begin
        raw = base;
        case (1'b1)
            pc_sel[SEL_VEC]:  raw = EXC_VEC;
            pc_sel[SEL_REG]:  raw = reg_target;
            pc_sel[SEL_JUMP]: raw = {base[31:28], pc_jump, 2'b00};
            pc_sel[SEL_ADD]:  raw = base + pc_offset;
            pc_sel[SEL_INC]:  raw = base;
            default:          raw = base;
        endcase
    end

    // Fetch addresses are always word aligned, including JR/JALR targets.
    assign target = raw & 32'hFFFF_FFFC;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage sequencer: owns the PC and the IF/ID register, runs the imem
// handshake and applies EX redirects, exceptions and stalls.
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4:0]            pc_sel,
    input  logic [31:0]           pc_offset,
    input  logic [25:0]           pc_jump,
    input  logic [31:0]           reg_target,
    input  logic [31:0]           ex_pc,
    input  logic                  br_valid,
    input  logic                  exc,
    input  logic                  stall,
    pc_sequencer_if.master        imem,
    output logic [31:0]           instr,
    output logic [31:0]           instr_pc,
    output logic                  instr_valid,
    output logic [31:0]           epc
);

    fetch_state_t state, state_next;
    fetch_entry_t skid, ifid;
    logic [31:0]  pc, pend_target, redirect_target, flush_target;
    logic         squash, redirect_ok, flush;

    pc_target u_target (
        .ex_pc      (ex_pc),
        .pc_sel     (pc_sel),
        .pc_offset  (pc_offset),
        .pc_jump    (pc_jump),
        .reg_target (reg_target),
        .target     (redirect_target)
    );

    assign redirect_ok  = br_valid & ~stall & ~exc & is_redirect(pc_sel);
    assign flush        = exc | redirect_ok;
    assign flush_target = exc ? EXC_VEC : redirect_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RST_WAIT;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RST_WAIT: state_next = REQ;
            REQ:      if (imem.iack && !flush && stall) state_next = SKID;
            SKID:     if (flush || !stall) state_next = REQ;
            default:  state_next = RST_WAIT;
        endcase
    end

    always_comb begin
        imem.ireq  = (state == REQ);
        imem.iaddr = pc;
    end

    // A redirect during an unacknowledged request is parked in pend_target so
    // the address stays stable until the memory answers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_VEC;
            pend_target <= '0;
            squash      <= 1'b0;
            skid        <= '0;
            ifid        <= '0;
            epc         <= '0;
        end else begin
            if (exc) epc <= ex_pc;

            case (state)
                RST_WAIT: if (flush) pc <= flush_target;
                REQ: begin
                    if (imem.iack) begin
                        squash <= 1'b0;
                        if (flush) begin
                            pc <= flush_target;
                        end else begin
                            pc <= squash ? pend_target : pc + 32'd4;
                            if (stall) skid <= '{instr: imem.idata, pc: pc, valid: ~squash};
                        end
                    end else if (flush) begin
                        squash      <= 1'b1;
                        pend_target <= flush_target;
                    end
                end
                SKID: begin
                    if (flush) begin
                        pc         <= flush_target;
                        skid.valid <= 1'b0;
                    end
                end
                default: ;
            endcase

            if (exc) begin
                ifid.valid <= 1'b0;
            end else if (!stall) begin
                if (state == REQ && imem.iack && !redirect_ok)
                    ifid <= '{instr: imem.idata, pc: pc, valid: ~squash};
                else if (state == SKID && !redirect_ok)
                    ifid <= skid;
                else
                    ifid.valid <= 1'b0;
            end
        end
    end

    assign instr       = ifid.instr;
    assign instr_pc    = ifid.pc;
    assign instr_valid = ifid.valid;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random
// EX traffic against a program-flow model with a variable-latency imem.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  pc_sel = 5'b00001;
    logic [31:0] pc_offset = '0;
    logic [25:0] pc_jump = '0;
    logic [31:0] reg_target = '0;
    logic [31:0] ex_pc = '0;
    logic        br_valid = 1'b0;
    logic        exc = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] instr, instr_pc, epc;
    logic        instr_valid;

    pc_sequencer_if imem();

    pc_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_sel      (pc_sel),
        .pc_offset   (pc_offset),
        .pc_jump     (pc_jump),
        .reg_target  (reg_target),
        .ex_pc       (ex_pc),
        .br_valid    (br_valid),
        .exc         (exc),
        .stall       (stall),
        .imem        (imem),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .epc         (epc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [31:0] target;
        logic        is_exc;
        logic [31:0] epc_val;
    } flow_t;

    flow_t       flowQ[$];
    int          testsRun = 0;
    int          testsFailed = 0;
    int unsigned cycle = 0;
    int          memLo = 0;
    int          memHi = 0;
    int          consumed = 0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5EED_1234;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Drives one cycle of EX inputs and records the program-flow change it implies.
    task automatic applyStimulus(input logic b, input logic [4:0] sel, input logic [31:0] xpc,
                                 input logic [31:0] off, input logic [25:0] jmp,
                                 input logic [31:0] rt, input logic e, input logic s);
        logic [31:0] base;
        logic [31:0] tgt;
        br_valid = b; pc_sel = sel; ex_pc = xpc; pc_offset = off;
        pc_jump = jmp; reg_target = rt; exc = e; stall = s;
        base = xpc + 32'd4;
        tgt = base;
        if (e) begin
            flowQ.push_back('{cyc: cycle, target: EXC_VEC, is_exc: 1'b1, epc_val: xpc});
        end else if (b && !s && sel != 5'b00001) begin
            if (sel == 5'b00010)      tgt = base + off;
            else if (sel == 5'b00100) tgt = {base[31:28], jmp, 2'b00};
            else if (sel == 5'b01000) tgt = rt & 32'hFFFF_FFFC;
            else                      tgt = EXC_VEC;
            flowQ.push_back('{cyc: cycle, target: tgt, is_exc: 1'b0, epc_val: 32'h0});
        end
    endtask

    task automatic idleStimulus();
        applyStimulus(1'b0, 5'b00001, 32'h0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b0);
    endtask

    always @(posedge clk) cycle++;

    // Instruction memory: random wait states per transaction.
    int  memCnt = 0;
    bit  memBusy = 1'b0;
    always @(posedge clk) begin
        #1;
        imem.iack = 1'b0;
        if (!rst_n || !imem.ireq) begin
            memBusy = 1'b0;
        end else begin
            if (!memBusy) begin
                memBusy = 1'b1;
                memCnt = $urandom_range(memHi, memLo);
            end
            if (memCnt == 0) begin
                imem.iack  = 1'b1;
                imem.idata = memWord(imem.iaddr);
                memBusy    = 1'b0;
            end else begin
                memCnt--;
            end
        end
    end

    // Monitor: checks every consumed instruction against the expected program order.
    logic [31:0] expNext = RESET_VEC;
    logic [31:0] expEpc = '0;
    logic [31:0] prevAddr = '0;
    bit          prevPending = 1'b0;
    bit          epcCheck = 1'b0;
    int          idle = 0;
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            expNext = RESET_VEC;
            flowQ.delete();
            prevPending = 1'b0;
            epcCheck = 1'b0;
            idle = 0;
        end else begin
            if (epcCheck) begin
                checkOutput("mon_epc", epc, expEpc);
                epcCheck = 1'b0;
            end
            if (prevPending && imem.ireq) checkOutput("mon_iaddr_stable", imem.iaddr, prevAddr);
            if (imem.ireq) checkOutput("mon_iaddr_align", 32'(imem.iaddr[1:0]), 32'h0);
            prevPending = imem.ireq && !imem.iack;
            prevAddr = imem.iaddr;
            idle++;
            if (instr_valid && !stall && !exc) begin
                checkOutput("mon_instr_pc", instr_pc, expNext);
                checkOutput("mon_instr", instr, memWord(expNext));
                expNext = expNext + 32'd4;
                consumed++;
                idle = 0;
            end
            if (flowQ.size() > 0 && flowQ[0].cyc == cycle) begin
                flow_t f;
                f = flowQ.pop_front();
                expNext = f.target;
                if (f.is_exc) begin
                    expEpc = f.epc_val;
                    epcCheck = 1'b1;
                end
                idle = 0;
            end
            if (idle > 60) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL mon_watchdog at %0t: got %0d idle cycles, expected at most 60", $time, idle);
                idle = 0;
            end
        end
    end

    initial begin
        logic [31:0] r;
        idleStimulus();
        repeat (2) @(negedge clk);
        checkOutput("rst_ireq", 32'(imem.ireq), 32'h0);
        checkOutput("rst_iaddr", imem.iaddr, RESET_VEC);
        checkOutput("rst_valid", 32'(instr_valid), 32'h0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_instr_pc", instr_pc, 32'h0);
        checkOutput("rst_epc", epc, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("boot_ireq", 32'(imem.ireq), 32'h1);
            checkOutput("boot_iaddr", imem.iaddr, RESET_VEC + 32'(4 * i));
            checkOutput("boot_valid", 32'(instr_valid), (i > 0) ? 32'h1 : 32'h0);
            if (i > 0) checkOutput("boot_instr_pc", instr_pc, RESET_VEC + 32'(4 * (i - 1)));
        end

        // Taken BEQ at 0x100 while the 0x108 fetch waits two cycles.
        applyStimulus(1'b1, 5'b01000, 32'h0, 32'h0, 26'h0, 32'h100, 1'b0, 1'b0);
        @(negedge clk); idleStimulus();
        checkOutput("beq_setup_iaddr", imem.iaddr, 32'h100);
        @(negedge clk);
        memLo = 2; memHi = 2;
        checkOutput("beq_fetch_104", imem.iaddr, 32'h104);
        @(negedge clk);
        checkOutput("beq_inflight_108", imem.iaddr, 32'h108);
        checkOutput("beq_delay_slot_pc", instr_pc, 32'h104);
        checkOutput("beq_delay_slot_valid", 32'(instr_valid), 32'h1);
        applyStimulus(1'b1, 5'b00010, 32'h100, 32'h20, 26'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk); idleStimulus();
        checkOutput("beq_addr_hold", imem.iaddr, 32'h108);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checkOutput("beq_squash_valid", 32'(instr_valid), 32'h0);
            if (imem.iaddr != 32'h108) break;
        end
        checkOutput("beq_target", imem.iaddr, 32'h124);
        memLo = 0; memHi = 0;
        repeat (4) @(negedge clk);

        applyStimulus(1'b1, 5'b00100, 32'h1000_0010, 32'h0, 26'h40, 32'h0, 1'b0, 1'b0);
        @(negedge clk); idleStimulus();
        checkOutput("jal_target", imem.iaddr, 32'h1000_0100);
        applyStimulus(1'b1, 5'b01000, 32'h0, 32'h0, 26'h0, 32'h2003, 1'b0, 1'b0);
        @(negedge clk); idleStimulus();
        checkOutput("jr_target", imem.iaddr, 32'h2000);

        // Three-cycle stall arriving with the 0x40 acknowledge.
        applyStimulus(1'b1, 5'b01000, 32'h0, 32'h0, 26'h0, 32'h3C, 1'b0, 1'b0);
        @(negedge clk); idleStimulus();
        checkOutput("stall_setup", imem.iaddr, 32'h3C);
        @(negedge clk);
        checkOutput("stall_fetch_40", imem.iaddr, 32'h40);
        applyStimulus(1'b0, 5'b00001, 32'h0, 32'h0, 26'h0, 32'h0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("stall_hold_pc", instr_pc, 32'h3C);
            checkOutput("stall_hold_valid", 32'(instr_valid), 32'h1);
            checkOutput("stall_ireq_low", 32'(imem.ireq), 32'h0);
        end
        idleStimulus();
        @(negedge clk);
        checkOutput("stall_release_pc", instr_pc, 32'h40);
        checkOutput("stall_release_instr", instr, memWord(32'h40));
        checkOutput("stall_release_valid", 32'(instr_valid), 32'h1);
        checkOutput("stall_next_iaddr", imem.iaddr, 32'h44);

        applyStimulus(1'b0, 5'b00001, 32'h200, 32'h0, 26'h0, 32'h0, 1'b1, 1'b1);
        @(negedge clk); idleStimulus();
        checkOutput("exc_epc", epc, 32'h200);
        checkOutput("exc_valid", 32'(instr_valid), 32'h0);
        checkOutput("exc_iaddr", imem.iaddr, EXC_VEC);

        // Reset pulse during an outstanding request.
        memLo = 3; memHi = 3;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (imem.ireq && !imem.iack) break;
        end
        checkOutput("midreq_pending", 32'(imem.ireq && !imem.iack), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreq_ireq_drop", 32'(imem.ireq), 32'h0);
        checkOutput("midreq_pc", imem.iaddr, RESET_VEC);
        checkOutput("midreq_valid", 32'(instr_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        memLo = 0; memHi = 0;
        @(negedge clk);
        checkOutput("midreq_refetch", imem.iaddr, RESET_VEC);
        applyStimulus(1'b1, 5'b01000, 32'h300, 32'h0, 26'h0, 32'h5000, 1'b1, 1'b0);
        @(negedge clk); idleStimulus();
        checkOutput("excbr_iaddr", imem.iaddr, EXC_VEC);
        checkOutput("excbr_epc", epc, 32'h300);
        checkOutput("excbr_valid", 32'(instr_valid), 32'h0);

        memLo = 0; memHi = 3;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            r = $urandom;
            applyStimulus(($urandom % 6) == 0, 5'(5'b00001 << $urandom_range(4, 0)),
                          $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                          26'($urandom), $urandom, ($urandom % 40) == 0, r[1:0] == 2'b00);
        end
        @(negedge clk); idleStimulus();
        repeat (20) @(negedge clk);
        checkOutput("stream_progress", 32'(consumed > 500), 32'h1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
